// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC and drives the I-mem read port.
// A redirect squashes the fetch issued in its own cycle, which costs one bubble.
module inst_fetch #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  hold_flag_i,
  input  logic                  jump_en_i,
  input  logic [31:0]           jump_addr_i,
  output logic                  mem_ren_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [31:0]           inst_addr_o,
  output logic                  inst_valid_o,
  output logic                  misalign_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        fetch_vld_q, fetch_vld_d;
  logic        squash_q, squash_d;
  logic        misalign_q, misalign_d;

  assign mem_ren_o   = ~hold_flag_i | jump_en_i;
  assign mem_raddr_o = pc_q[ADDR_WIDTH+1:2];

  always_comb begin
    pc_d = pc_q;
    priority case (1'b1)
      jump_en_i:   pc_d = {jump_addr_i[31:2], 2'b00};
      hold_flag_i: pc_d = pc_q;
      default:     pc_d = pc_q + 32'd4;
    endcase
  end

  // Tracking state freezes with the memory so a hold keeps output stable
  always_comb begin
    inst_addr_d = inst_addr_q;
    fetch_vld_d = fetch_vld_q;
    squash_d    = squash_q;
    if (mem_ren_o) begin
      inst_addr_d = pc_q;
      fetch_vld_d = 1'b1;
      squash_d    = jump_en_i;
    end
  end

  always_comb begin
    misalign_d = jump_en_i & (jump_addr_i[1:0] != 2'b00);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pc_q        <= RESET_PC;
      inst_addr_q <= RESET_PC;
      fetch_vld_q <= 1'b0;
      squash_q    <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      inst_addr_q <= inst_addr_d;
      fetch_vld_q <= fetch_vld_d;
      squash_q    <= squash_d;
      misalign_q  <= misalign_d;
    end
  end

  assign inst_valid_o = fetch_vld_q & ~squash_q;
  assign inst_o       = inst_valid_o ? mem_rdata_i : NOP_INST;
  assign inst_addr_o  = inst_addr_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a registered-read I-mem model.
// Memory word i holds 0xA000_0000 + i.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        jump;
  logic [31:0] jaddr;
  logic        ren;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic [31:0] iaddr;
  logic        ivld;
  logic        mis;

  logic [31:0] mem [4096];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ren) rdata <= mem[raddr];
  end

  inst_fetch dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .hold_flag_i  (hold),
    .jump_en_i    (jump),
    .jump_addr_i  (jaddr),
    .mem_ren_o    (ren),
    .mem_raddr_o  (raddr),
    .mem_rdata_i  (rdata),
    .inst_o       (inst),
    .inst_addr_o  (iaddr),
    .inst_valid_o (ivld),
    .misalign_o   (mis)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string tag,
                     input logic [31:0] ei,
                     input logic [31:0] ea,
                     input logic        ev);
    chk({tag, ".inst"}, inst, ei);
    chk({tag, ".addr"}, iaddr, ea);
    chk({tag, ".vld"}, {31'd0, ivld}, {31'd0, ev});
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 + i;
    rdata = '0;
    rst_n = 1'b0;
    hold  = 1'b0;
    jump  = 1'b0;
    jaddr = '0;
    tick();
    tick();
    out("rst", NOP, 32'h0, 1'b0);
    chk("rst.mis", {31'd0, mis}, 32'd0);
    chk("rst.raddr", {20'd0, raddr}, 32'h0);
    rst_n = 1'b1;

    tick(); out("a0", 32'hA000_0000, 32'h0, 1'b1);
    tick(); out("a1", 32'hA000_0001, 32'h4, 1'b1);

    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      out("hold", 32'hA000_0001, 32'h4, 1'b1);
      chk("hold.ren", {31'd0, ren}, 32'd0);
      chk("hold.raddr", {20'd0, raddr}, 32'h2);
      tick();
    end
    out("hold.end", 32'hA000_0001, 32'h4, 1'b1);
    hold = 1'b0;
    tick(); out("a2", 32'hA000_0002, 32'h8, 1'b1);
    tick(); out("a3", 32'hA000_0003, 32'hC, 1'b1);

    jump = 1'b1; jaddr = 32'h100;
    #1;
    chk("j1.raddr", {20'd0, raddr}, 32'h4);
    chk("j1.ren", {31'd0, ren}, 32'd1);
    tick(); out("j1.sq", NOP, 32'h10, 1'b0);
    jump = 1'b0;
    tick(); out("j1.t0", 32'hA000_0040, 32'h100, 1'b1);
    tick(); out("j1.t1", 32'hA000_0041, 32'h104, 1'b1);

    jump = 1'b1; hold = 1'b1; jaddr = 32'h200;
    #1;
    chk("jh.ren", {31'd0, ren}, 32'd1);
    tick(); out("jh.sq", NOP, 32'h108, 1'b0);
    jump = 1'b0;
    tick(); out("jh.sq2", NOP, 32'h108, 1'b0);
    hold = 1'b0;
    tick(); out("jh.t0", 32'hA000_0080, 32'h200, 1'b1);

    jump = 1'b1; jaddr = 32'h102;
    tick();
    chk("mis.hi", {31'd0, mis}, 32'd1);
    out("mis.sq", NOP, 32'h204, 1'b0);
    jump = 1'b0;
    tick();
    chk("mis.lo", {31'd0, mis}, 32'd0);
    out("mis.t0", 32'hA000_0040, 32'h100, 1'b1);

    jump = 1'b1; jaddr = 32'h3FFC;
    tick();
    chk("wr.raddr0", {20'd0, raddr}, 32'hFFF);
    chk("wr.mis", {31'd0, mis}, 32'd0);
    jump = 1'b0;
    tick();
    out("wr.t0", 32'hA000_0FFF, 32'h3FFC, 1'b1);
    chk("wr.raddr1", {20'd0, raddr}, 32'h000);
    tick();
    out("wr.t1", 32'hA000_0000, 32'h4000, 1'b1);

    rst_n = 1'b0;
    tick();
    out("rst2", NOP, 32'h0, 1'b0);
    chk("rst2.raddr", {20'd0, raddr}, 32'h0);
    rst_n = 1'b1;
    tick(); out("rst2.a0", 32'hA000_0000, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
